adc_cfg_spi: RTL and testbench

//  Serial-write engine for the ADS5282 configuration port. Sits directly downstream of the automatic

---
 rtl/adc_cfg_pkg.sv | 27 ++
 rtl/adc_cfg_spi_if.sv | 27 ++
 rtl/adc_cfg_sclk_gen.sv | 41 ++++
 rtl/adc_cfg_spi.sv | 153 +++++++++++++++
 tb/tb_adc_cfg_spi.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_cfg_pkg.sv
// Shared constants for the ADS5282 configuration serial-write engine.
// State encodings, word layout and a small sizing helper.
package adc_cfg_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_SHIFT = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;

   localparam int ADC_CFG_WORD_W   = 24;
   localparam int ADC_CFG_ADDR_MSB = 23;
   localparam int ADC_CFG_DATA_MSB = 15;

   typedef logic [ADC_CFG_WORD_W-1:0] cfg_word_t;

   function automatic int max4(input int a, input int b,
                               input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/adc_cfg_spi_if.sv
// Request/status handshake and ADC serial pins of the config engine.
// master = configuration FSM side, slave = serial-write engine.
interface adc_cfg_spi_if;
   import adc_cfg_pkg::*;

   logic      start;
   cfg_word_t cfg_word;
   logic      busy;
   logic      end_conf;
   logic      cfg_err;
   logic      adc_csn;
   logic      adc_sclk;
   logic      adc_sdata;

   modport master (
      output start, cfg_word,
      input  busy, end_conf, cfg_err,
      input  adc_csn, adc_sclk, adc_sdata
   );

   modport slave (
      input  start, cfg_word,
      output busy, end_conf, cfg_err,
      output adc_csn, adc_sclk, adc_sdata
   );

endinterface

// File: rtl/adc_cfg_sclk_gen.sv
// SCLK phase counter for the config engine; runs only while en is high.
// Each phase lasts CLK_DIV cycles; low phase first, then high phase.
module adc_cfg_sclk_gen #(
   parameter int CLK_DIV = 4,
   parameter int CW      = 3
) (
   input  logic clk,
   input  logic rstb,
   input  logic en,
   output logic sclk_ph,
   output logic fall_tick,
   output logic period_end
);

   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          ph_last;

   // Phase counter: reload when idle and on every phase change.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         cnt     <= '0;
         sclk_ph <= 1'b0;
      end else if (!en) begin
         cnt     <= RELOAD;
         sclk_ph <= 1'b0;
      end else if (cnt == '0) begin
         cnt     <= RELOAD;
         sclk_ph <= ~sclk_ph;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   assign ph_last    = en && (cnt == '0);
   // Last cycle of the high phase: sclk drops and the bit period ends together.
   assign fall_tick  = ph_last && sclk_ph;
   assign period_end = ph_last && sclk_ph;

endmodule

// File: rtl/adc_cfg_spi.sv
// ADS5282 configuration serial-write engine: one 24-bit word per start.
// Optional sticky protocol error flag: define ADC_CFG_ERR_EN.
module adc_cfg_spi
   import adc_cfg_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_GAP   = 4
) (
   input  logic          clk,
   input  logic          rstb,
   adc_cfg_spi_if.slave  cfg_bus
);

   localparam int CW =
      $clog2(max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP) + 1);

   localparam logic [CW-1:0] LD_SETUP = CW'(CS_SETUP - 1);
   localparam logic [CW-1:0] LD_HOLD  = CW'(CS_HOLD - 1);
   localparam logic [CW-1:0] LD_GAP   = CW'(CS_GAP - 1);

   logic [2:0]    state;
   logic [CW-1:0] st_cnt;
   logic [4:0]    bit_cnt;
   cfg_word_t     sr;

   logic sclk_ph;
   logic fall_tick;
   logic period_end;
   logic shift_en;
   logic accept;
   logic frame_act;

   logic busy_q;
   logic end_conf_q;
   logic csn_q;
   logic sclk_q;
   logic sdata_q;

   assign shift_en  = (state == ST_SHIFT);
   assign frame_act = (state == ST_SETUP) || shift_en ||
                      (state == ST_HOLD);
   // busy still high in the end_conf cycle blocks a same-cycle restart.
   assign accept    = (state == ST_IDLE) && !busy_q &&
                      cfg_bus.start;

   adc_cfg_sclk_gen #(
      .CLK_DIV (CLK_DIV),
      .CW      (CW)
   ) u_sclk_gen (
      .clk        (clk),
      .rstb       (rstb),
      .en         (shift_en),
      .sclk_ph    (sclk_ph),
      .fall_tick  (fall_tick),
      .period_end (period_end)
   );

   // Frame sequencer: state, dwell counter, bit counter, shift register.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         state   <= ST_IDLE;
         st_cnt  <= '0;
         bit_cnt <= '0;
         sr      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  sr     <= cfg_bus.cfg_word;
                  st_cnt <= LD_SETUP;
                  state  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (st_cnt == '0) begin
                  bit_cnt <= 5'd23;
                  state   <= ST_SHIFT;
               end else begin
                  st_cnt <= st_cnt - 1'b1;
               end
            end
            ST_SHIFT: begin
               if (period_end && (bit_cnt == 5'd0)) begin
                  st_cnt <= LD_HOLD;
                  state  <= ST_HOLD;
               end else if (fall_tick) begin
                  sr      <= {sr[ADC_CFG_WORD_W-2:0], 1'b0};
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            ST_HOLD: begin
               if (st_cnt == '0) begin
                  st_cnt <= LD_GAP;
                  state  <= ST_GAP;
               end else begin
                  st_cnt <= st_cnt - 1'b1;
               end
            end
            ST_GAP: begin
               if (st_cnt == '0) begin
                  state <= ST_IDLE;
               end else begin
                  st_cnt <= st_cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Registered pin and status outputs, one cycle behind the sequencer.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         busy_q     <= 1'b0;
         end_conf_q <= 1'b0;
         csn_q      <= 1'b1;
         sclk_q     <= 1'b0;
         sdata_q    <= 1'b0;
      end else begin
         busy_q     <= (state != ST_IDLE);
         end_conf_q <= (state == ST_GAP) && (st_cnt == '0);
         csn_q      <= !frame_act;
         sclk_q     <= shift_en && sclk_ph;
         sdata_q    <= frame_act && sr[ADC_CFG_ADDR_MSB];
      end
   end

   assign cfg_bus.busy      = busy_q;
   assign cfg_bus.end_conf  = end_conf_q;
   assign cfg_bus.adc_csn   = csn_q;
   assign cfg_bus.adc_sclk  = sclk_q;
   assign cfg_bus.adc_sdata = sdata_q;

`ifdef ADC_CFG_ERR_EN
   logic err_q;

   // Sticky flag: a request arrived while a frame was still running.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         err_q <= 1'b0;
      end else if (cfg_bus.start && busy_q) begin
         err_q <= 1'b1;
      end
   end

   assign cfg_bus.cfg_err = err_q;
`else
   assign cfg_bus.cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_cfg_spi.sv
// Directed bench for adc_cfg_spi: default and minimum-timing instances.
// Cycle n is sampled on the falling edge n clocks after the start edge.
module tb_adc_cfg_spi;
   import adc_cfg_pkg::*;

   logic clk = 1'b0;
   logic rstb = 1'b0;

   always #5 clk = ~clk;

   adc_cfg_spi_if ia ();
   adc_cfg_spi_if ib ();

   adc_cfg_spi #(
      .CLK_DIV (4), .CS_SETUP (2), .CS_HOLD (2), .CS_GAP (4)
   ) dut_a (
      .clk (clk), .rstb (rstb), .cfg_bus (ia.slave)
   );

   adc_cfg_spi #(
      .CLK_DIV (1), .CS_SETUP (1), .CS_HOLD (1), .CS_GAP (1)
   ) dut_b (
      .clk (clk), .rstb (rstb), .cfg_bus (ib.slave)
   );

   int n_run  = 0;
   int n_fail = 0;
   int viol   = 0;
   int sclk_hi_seen = 0;
   logic pa = 1'b0;
   logic pb = 1'b0;

`ifdef ADC_CFG_ERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   // Continuous pin-protocol watch on both instances.
   always @(negedge clk) begin
      if (ia.adc_sclk === 1'b1) begin
         sclk_hi_seen++;
         if (ia.adc_sdata !== pa) viol++;
      end
      if (ib.adc_sclk === 1'b1 && ib.adc_sdata !== pb) viol++;
      if (ia.adc_csn === 1'b1 && ia.adc_sclk !== 1'b0) viol++;
      if (ib.adc_csn === 1'b1 && ib.adc_sclk !== 1'b0) viol++;
      pa = ia.adc_sdata;
      pb = ib.adc_sdata;
   end

   task automatic send(input bit sel, input logic [23:0] w);
      if (sel) begin
         ib.start = 1'b1; ib.cfg_word = w;
      end else begin
         ia.start = 1'b1; ia.cfg_word = w;
      end
      @(posedge clk);
      #1;
      ia.start = 1'b0;
      ib.start = 1'b0;
   endtask

   task automatic observe(
      input  bit sel, input int ncyc,
      input  int inj_a, input int inj_b,
      output int csn_first, output int csn_last,
      output int csn_cnt, output int ec_cnt,
      output int ec_cyc, output int busy_first,
      output int busy_last, output int rises,
      output logic [23:0] bits
   );
      logic ps, csn, sclk, sd, ec, bz, st;
      ps = 1'b0;
      csn_first = -1; csn_last = -1; csn_cnt = 0;
      ec_cnt = 0; ec_cyc = -1;
      busy_first = -1; busy_last = -1;
      rises = 0; bits = '0;
      for (int n = 0; n <= ncyc; n++) begin
         @(negedge clk);
         st = (n == inj_a) || (n == inj_b);
         if (sel) begin
            ib.start = st;
            if (n == 10) ib.cfg_word = 24'hC3_3C5A;
            csn = ib.adc_csn; sclk = ib.adc_sclk;
            sd = ib.adc_sdata; ec = ib.end_conf;
            bz = ib.busy;
         end else begin
            ia.start = st;
            if (n == 10) ia.cfg_word = 24'hC3_3C5A;
            csn = ia.adc_csn; sclk = ia.adc_sclk;
            sd = ia.adc_sdata; ec = ia.end_conf;
            bz = ia.busy;
         end
         if (csn === 1'b0) begin
            if (csn_first < 0) csn_first = n;
            csn_last = n;
            csn_cnt++;
         end
         if (ec === 1'b1) begin
            ec_cnt++;
            ec_cyc = n;
         end
         if (bz === 1'b1) begin
            if (busy_first < 0) busy_first = n;
            busy_last = n;
         end
         if (sclk === 1'b1 && ps === 1'b0) begin
            rises++;
            bits = {bits[22:0], sd};
         end
         ps = sclk;
      end
      ia.start = 1'b0;
      ib.start = 1'b0;
   endtask

   int cf, cl, cc, ecn, ecc, bf, bl, rs;
   logic [23:0] bt;

   task automatic test_reset();
      rstb = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_run++;
      if ({ia.adc_csn, ia.adc_sclk, ia.adc_sdata, ia.busy,
           ia.end_conf, ia.cfg_err} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_a got %b exp 100000",
            {ia.adc_csn, ia.adc_sclk, ia.adc_sdata, ia.busy,
             ia.end_conf, ia.cfg_err});
      end
      n_run++;
      if ({ib.adc_csn, ib.adc_sclk, ib.adc_sdata, ib.busy,
           ib.end_conf, ib.cfg_err} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_b got %b exp 100000",
            {ib.adc_csn, ib.adc_sclk, ib.adc_sdata, ib.busy,
             ib.end_conf, ib.cfg_err});
      end
      rstb = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic chk(input string nm, input int got, input int exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %0d exp %0d", nm, got, exp);
      end
   endtask

   task automatic test_single();
      send(0, 24'h0A_5A5A);
      observe(0, 201, -1, -1, cf, cl, cc, ecn, ecc, bf, bl, rs, bt);
      n_run++;
      if (cf !== 1 || cl !== 196 || cc !== 196) begin
         n_fail++;
         $display("FAIL single_csn got %0d..%0d n=%0d exp 1..196 n=196",
            cf, cl, cc);
      end
      n_run++;
      if (rs !== 24) begin
         n_fail++;
         $display("FAIL single_rises got %0d exp 24", rs);
      end
      n_run++;
      if (bt !== 24'h0A5A5A) begin
         n_fail++;
         $display("FAIL single_bits got %h exp 0a5a5a", bt);
      end
      n_run++;
      if (ecn !== 1 || ecc !== 200) begin
         n_fail++;
         $display("FAIL single_end_conf got n=%0d @%0d exp n=1 @200",
            ecn, ecc);
      end
      n_run++;
      if (bf !== 1 || bl !== 200) begin
         n_fail++;
         $display("FAIL single_busy got %0d..%0d exp 1..200", bf, bl);
      end
   endtask

   task automatic test_back_to_back();
      int gap;
      send(0, 24'hFF_0001);
      observe(0, 201, -1, -1, cf, cl, cc, ecn, ecc, bf, bl, rs, bt);
      gap = (202 + cf) - 197;
      n_run++;
      if (cf !== 1 || cl !== 196 || cc !== 196) begin
         n_fail++;
         $display("FAIL b2b_csn got %0d..%0d n=%0d exp 1..196 n=196",
            cf, cl, cc);
      end
      n_run++;
      if (gap !== 6) begin
         n_fail++;
         $display("FAIL b2b_gap got %0d exp 6", gap);
      end
      n_run++;
      if (bt !== 24'hFF0001 || rs !== 24) begin
         n_fail++;
         $display("FAIL b2b_bits got %h/%0d exp ff0001/24", bt, rs);
      end
      n_run++;
      if (ecn !== 1 || ecc !== 200 || bl !== 200) begin
         n_fail++;
         $display("FAIL b2b_end got n=%0d @%0d busy_last=%0d exp 1 @200 200",
            ecn, ecc, bl);
      end
      n_run++;
      if (ia.cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_no_err got %b exp 0", ia.cfg_err);
      end
   endtask

   task automatic test_busy_start();
      send(0, 24'h5A_0F0F);
      observe(0, 215, 50, 200, cf, cl, cc, ecn, ecc, bf, bl, rs, bt);
      n_run++;
      if (cf !== 1 || cl !== 196 || cc !== 196) begin
         n_fail++;
         $display("FAIL busy_csn got %0d..%0d n=%0d exp 1..196 n=196",
            cf, cl, cc);
      end
      n_run++;
      if (bt !== 24'h5A0F0F || rs !== 24) begin
         n_fail++;
         $display("FAIL busy_bits got %h/%0d exp 5a0f0f/24", bt, rs);
      end
      n_run++;
      if (ecn !== 1 || ecc !== 200 || bl !== 200) begin
         n_fail++;
         $display("FAIL busy_end got n=%0d @%0d busy_last=%0d exp 1 @200 200",
            ecn, ecc, bl);
      end
      n_run++;
      if (ia.cfg_err !== EXP_ERR) begin
         n_fail++;
         $display("FAIL busy_cfg_err got %b exp %b", ia.cfg_err, EXP_ERR);
      end
   endtask

   task automatic test_reset_abort();
      logic csn100;
      int ec_seen;
      send(0, 24'h33_CC55);
      for (int n = 0; n <= 100; n++) @(negedge clk);
      csn100 = ia.adc_csn;
      rstb = 1'b0;
      @(negedge clk);
      n_run++;
      if (csn100 !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_live got csn=%b exp 0", csn100);
      end
      n_run++;
      if ({ia.adc_csn, ia.adc_sclk, ia.adc_sdata, ia.busy,
           ia.end_conf, ia.cfg_err} !== 6'b100000) begin
         n_fail++;
         $display("FAIL abort_outs got %b exp 100000",
            {ia.adc_csn, ia.adc_sclk, ia.adc_sdata, ia.busy,
             ia.end_conf, ia.cfg_err});
      end
      rstb = 1'b1;
      ec_seen = 0;
      for (int n = 0; n < 120; n++) begin
         @(negedge clk);
         if (ia.end_conf === 1'b1) ec_seen++;
      end
      chk("abort_no_end_conf", ec_seen, 0);
      send(0, 24'hC3_81E7);
      observe(0, 201, -1, -1, cf, cl, cc, ecn, ecc, bf, bl, rs, bt);
      n_run++;
      if (cf !== 1 || cl !== 196 || cc !== 196) begin
         n_fail++;
         $display("FAIL abort_csn got %0d..%0d n=%0d exp 1..196 n=196",
            cf, cl, cc);
      end
      n_run++;
      if (bt !== 24'hC381E7 || rs !== 24) begin
         n_fail++;
         $display("FAIL abort_bits got %h/%0d exp c381e7/24", bt, rs);
      end
      chk("abort_end_conf_cycle", ecc, 200);
   endtask

   task automatic test_fast();
      send(1, 24'h80_0001);
      observe(1, 55, -1, -1, cf, cl, cc, ecn, ecc, bf, bl, rs, bt);
      n_run++;
      if (cf !== 1 || cl !== 50 || cc !== 50) begin
         n_fail++;
         $display("FAIL fast_csn got %0d..%0d n=%0d exp 1..50 n=50",
            cf, cl, cc);
      end
      n_run++;
      if (bt !== 24'h800001 || rs !== 24) begin
         n_fail++;
         $display("FAIL fast_bits got %h/%0d exp 800001/24", bt, rs);
      end
      n_run++;
      if (ecn !== 1 || ecc !== 51 || bf !== 1 || bl !== 51) begin
         n_fail++;
         $display("FAIL fast_end got n=%0d @%0d busy %0d..%0d exp 1 @51 1..51",
            ecn, ecc, bf, bl);
      end
   endtask

   task automatic test_monitor();
      n_run++;
      if (viol !== 0) begin
         n_fail++;
         $display("FAIL monitor_violations got %0d exp 0", viol);
      end
      n_run++;
      if (sclk_hi_seen < 1) begin
         n_fail++;
         $display("FAIL monitor_activity got %0d exp >0", sclk_hi_seen);
      end
   endtask

   initial begin
      ia.start = 1'b0; ia.cfg_word = '0;
      ib.start = 1'b0; ib.cfg_word = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_busy_start();
      test_reset_abort();
      test_fast();
      test_monitor();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
